phase_shift_generator: RTL and testbench
========================================

// Module: phase_shift_generator
// PURPOSE
//  - Generates one phase-programmable square-wave drive (default 40 kHz) for an acoustic levitator transducer channel.
//  - A 50 MHz system clock is reduced internally to a 5 MHz tick enable.
//  - A waveform counter, a latched 7-bit phase offset and a registered compare produce the output.
//  - Sits between the host phase-command interface and the transducer driver pins.
// PARAMETERS
//  - DIV         10   system clocks per tick (50 MHz -> 5 MHz enable)
//  - PERIOD      125  ticks per output period (5 MHz / 125 = 40 kHz)
//  - HIGH_TICKS  62   ticks per period that clock_out is high (PERIOD/2, floor)
// PORTS
//  - clock_in     in   1  system clock, 50 MHz; the only clock, rising edge
//  - reset_n      in   1  asynchronous, active-low reset
//  - phase_shift  in   7  requested delay in ticks (200 ns each), unsigned
//  - apply_shift  in   1  level request, synchronous to clock_in; its rising edge loads phase_shift
//  - clock_out    out  1  phase-shifted square wave, registered
//  - tick         out  1  1-cycle 5 MHz enable, exported for sibling channels
// BEHAVIOUR
//  - Reset values: all registers are 0 while reset_n=0. Outputs clock_out=0, tick=0.
//  - Reset state: div_cnt=0, wave_cnt=0, active_phase=0, pending=0.
//  - Divider:
//    - div_cnt counts 0..DIV-1 on every clock_in edge.
//    - tick=1 for exactly the cycle where div_cnt==DIV-1; tick period is 10 clocks.
//  - Wave counter:
//    - On tick, wave_cnt counts 0..PERIOD-1, then wraps to 0.
//  - Shift compare:
//    - shifted = (wave_cnt>=active_phase) ? wave_cnt-active_phase : wave_cnt+PERIOD-active_phase.
//    - On tick, clock_out <= (shifted < HIGH_TICKS).
//    - clock_out changes only on tick cycles, so it is glitch-free.
//  - Apply handshake:
//    - apply_shift is registered once (apply_d). A rise is apply_shift & ~apply_d.
//    - On a rise, pending_phase is loaded with the normalised phase_shift, and pending is set to 1.
//    - Normalisation: values >= PERIOD (125..127) are reduced by PERIOD, giving 0..2.
//    - Holding apply_shift high does not reload. Only one load happens per rising edge.
//    - apply_shift pulses shorter than one tick are still captured.
//  - Commit:
//    - pending_phase is copied into active_phase on the commit condition below, then pending clears.
//    - Worst-case latency from the rise to the new phase is 1 period = 1250 clocks.
//  - Boundary cases:
//    - A rise in the same cycle as a commit: the new rise overrides pending_phase, and pending stays 1.
//    - If several rises occur before a commit, the last one wins.
//    - Phase 0 gives a waveform identical to the unshifted reference.
//    - reset_n deasserting mid-period restarts the waveform from wave_cnt=0 and discards the pending shift.
// CONFIGURATION
//  - Macro PHASE_SYNC_APPLY_EN.
//  - Defined: commit happens only on a tick with wave_cnt==PERIOD-1, i.e. at the period boundary.
//    - No runt pulses at a phase change.
//  - Undefined: commit happens on the next tick after the rise.
//    - Lower latency (<=10 clocks).
//    - One shortened or lengthened half-cycle is permitted.
// STRUCTURE
//  - Shared package phase_gen_pkg: PHASE_W=7, default DIV/PERIOD/HIGH_TICKS, typedef phase_t (logic [6:0]).
//  - One sub-module, tick_divider: counter producing the tick enable (parameter DIV).
//  - Everything else lives in this module.
//  - No derived or gated clocks: all logic is clocked by clock_in and qualified by tick.
// TESTING
//  - Reset: hold reset_n=0 for 5 cycles -> clock_out=0, tick=0. After release, tick pulses every 10 clocks.
//  - Phase 0: run 3 periods -> clock_out period is 1250 clocks, high for 620 clocks, low for 630.
//  - Phase 15: with PHASE_SYNC_APPLY_EN, apply_shift high for 64 clocks.
//    - From the following period on, each rising edge lags the phase-0 edge by 150 clocks.
//    - The period stays 1250; no runt pulses.
//  - Wrap: phase_shift=127, apply -> behaves as phase 2, lag 20 clocks.
//  - Short pulse and override: two 1-clock apply pulses (phase 30, then 60) within one period -> only phase 60 takes effect.
//  - Reset mid-operation: assert reset_n=0 for 3 clocks at wave_cnt~70 with a shift pending.
//    - clock_out drops to 0 immediately.
//    - After release, the waveform restarts at phase 0.

Source files
------------

// File: rtl/phase_gen_pkg.sv
// Shared constants and types for the phase-programmable transducer drive channels.
package phase_gen_pkg;
  localparam int PHASE_W    = 7;
  localparam int DIV        = 10;
  localparam int PERIOD     = 125;
  localparam int HIGH_TICKS = 62;

  typedef logic [PHASE_W-1:0] phase_t;

  // Folds out-of-range requests (PERIOD..2^PHASE_W-1) back into 0..PERIOD-1.
  function automatic phase_t norm_phase(input phase_t p, input int period);
    if (int'(p) >= period) return phase_t'(int'(p) - period);
    return p;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// Free-running divide-by-DIV counter; tick is high for the last count of each cycle.
module tick_divider #(
  parameter int DIV = 10
) (
  input  logic clock_in,
  input  logic reset_n,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)                     div_cnt <= '0;
    else if (div_cnt == CW'(DIV - 1)) div_cnt <= '0;
    else                              div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == CW'(DIV - 1));
endmodule

// File: rtl/phase_shift_generator.sv
// Phase-shifted square-wave drive for one levitator transducer channel.
// Build option PHASE_SYNC_APPLY_EN: defer phase commits to the period boundary.
module phase_shift_generator
  import phase_gen_pkg::*;
#(
  parameter int DIV        = phase_gen_pkg::DIV,
  parameter int PERIOD     = phase_gen_pkg::PERIOD,
  parameter int HIGH_TICKS = phase_gen_pkg::HIGH_TICKS
) (
  input  logic   clock_in,
  input  logic   reset_n,
  input  phase_t phase_shift,
  input  logic   apply_shift,
  output logic   clock_out,
  output logic   tick
);
  localparam int WW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = ((WW > PHASE_W) ? WW : PHASE_W) + 1;

  logic [WW-1:0] wave_cnt;
  phase_t        active_phase, pending_phase;
  logic          pending, apply_d;
  logic          apply_rise, commit;
  logic [SW-1:0] wave_ext, phase_ext, shifted;

  tick_divider #(.DIV(DIV)) u_div (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .tick     (tick)
  );

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)                             wave_cnt <= '0;
    else if (tick && wave_cnt == WW'(PERIOD - 1)) wave_cnt <= '0;
    else if (tick)                            wave_cnt <= wave_cnt + 1'b1;
  end

  // Distance from the shifted zero point, wrapped into 0..PERIOD-1.
  always_comb begin
    wave_ext  = SW'(wave_cnt);
    phase_ext = SW'(active_phase);
    shifted   = (wave_ext >= phase_ext) ? wave_ext - phase_ext
                                        : wave_ext + SW'(PERIOD) - phase_ext;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)  clock_out <= 1'b0;
    else if (tick) clock_out <= (shifted < SW'(HIGH_TICKS));
  end

  assign apply_rise = apply_shift & ~apply_d;

`ifdef PHASE_SYNC_APPLY_EN
  assign commit = tick & pending & (wave_cnt == WW'(PERIOD - 1));
`else
  assign commit = tick & pending;
`endif

  // A rise coinciding with a commit wins: the fresh request stays pending.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      apply_d       <= 1'b0;
      pending       <= 1'b0;
      pending_phase <= '0;
      active_phase  <= '0;
    end else begin
      apply_d <= apply_shift;
      if (commit) begin
        active_phase <= pending_phase;
        pending      <= 1'b0;
      end
      if (apply_rise) begin
        pending_phase <= norm_phase(phase_shift, PERIOD);
        pending       <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_phase_shift_generator.sv
// Bench for phase_shift_generator: cycle-level reference built from edge counts plus directed timing checks.
module tb_phase_shift_generator;
  logic       clock_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       apply_shift = 1'b0;
  logic [6:0] phase_shift = '0;
  logic       clock_out, tick;

  int total = 0;
  int bad = 0;

  always #10 clock_in = ~clock_in;

  phase_shift_generator dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .phase_shift (phase_shift),
    .apply_shift (apply_shift),
    .clock_out   (clock_out),
    .tick        (tick)
  );

  // Reference: edge e (0-based since reset release) carries a tick when e%10==9,
  // and that tick sees waveform position (e/10)%125.
  int mdl_edges = 0;
  int mdl_act = 0;
  int mdl_pph = 0;
  bit mdl_pend = 0;
  bit mdl_prev_apply = 0;
  bit mdl_out = 0;

  function automatic bit tick_at(input int e);
    return (e % 10) == 9;
  endfunction

  function automatic int wave_at(input int e);
    return (e / 10) % 125;
  endfunction

  function automatic bit commit_at(input int e, input bit pend);
`ifdef PHASE_SYNC_APPLY_EN
    return tick_at(e) && pend && (wave_at(e) == 124);
`else
    return tick_at(e) && pend;
`endif
  endfunction

  always @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      mdl_edges <= 0; mdl_act <= 0; mdl_pph <= 0;
      mdl_pend <= 0; mdl_prev_apply <= 0; mdl_out <= 0;
    end else begin
      mdl_edges      <= mdl_edges + 1;
      mdl_prev_apply <= apply_shift;
      if (tick_at(mdl_edges))
        mdl_out <= (((wave_at(mdl_edges) - mdl_act + 125) % 125) < 62);
      if (commit_at(mdl_edges, mdl_pend)) begin
        mdl_act  <= mdl_pph;
        mdl_pend <= 0;
      end
      if (apply_shift && !mdl_prev_apply) begin
        mdl_pph  <= int'(phase_shift) % 125;
        mdl_pend <= 1;
      end
    end
  end

  int  rise_t, fall_t, per, hi_w, lo_w;
  bit  prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic meas_clr();
    rise_t = 0; fall_t = 0; per = 0; hi_w = 0; lo_w = 0; prev_out = 0;
  endtask

  task automatic cyc();
    @(posedge clock_in); #1;
    chk("clock_out", {31'd0, clock_out}, {31'd0, mdl_out});
    chk("tick", {31'd0, tick}, {31'd0, (mdl_edges % 10) == 9});
    if (clock_out && !prev_out) begin
      if (rise_t > 0) per = mdl_edges - rise_t;
      if (fall_t > 0) lo_w = mdl_edges - fall_t;
      rise_t = mdl_edges;
    end
    if (!clock_out && prev_out) begin
      hi_w = mdl_edges - rise_t;
      fall_t = mdl_edges;
    end
    prev_out = clock_out;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic apply(input logic [6:0] p, input int len);
    phase_shift = p;
    apply_shift = 1'b1;
    run(len);
    apply_shift = 1'b0;
  endtask

  // Lag of the latest rising edge behind the phase-0 reference edge (edge index%1250==9).
  task automatic chk_lag(input string tag, input int exp);
    chk(tag, (rise_t + 1240) % 1250, exp);
  endtask

  task automatic wait_pos(input int pos);
    for (int i = 0; i < 1300 && (mdl_edges % 1250) != pos; i++) cyc();
    chk("wait_pos", mdl_edges % 1250, pos);
  endtask

  initial begin
    int p, last;
    meas_clr();

    repeat (5) @(posedge clock_in);
    #1;
    chk("reset_clock_out", {31'd0, clock_out}, 0);
    chk("reset_tick", {31'd0, tick}, 0);
    reset_n = 1'b1;

    // phase 0 over three periods
    run(3800);
    chk("p0_period", per, 1250);
    chk("p0_high", hi_w, 620);
    chk("p0_low", lo_w, 630);
    chk_lag("p0_lag", 0);

    apply(7'd15, 64);
    run(3750);
    chk_lag("p15_lag", 150);
    chk("p15_period", per, 1250);
    chk("p15_high", hi_w, 620);
    chk("p15_low", lo_w, 630);

    apply(7'd127, 3);
    run(3750);
    chk_lag("wrap_lag", 20);
    chk("wrap_period", per, 1250);

    wait_pos(50);
    apply(7'd30, 1);
    run(100);
    apply(7'd60, 1);
    run(3750);
    chk_lag("override_lag", 600);

    last = 60;
    for (int i = 0; i < 12; i++) begin
      p = int'($urandom_range(0, 127));
      apply(7'(p), int'($urandom_range(1, 80)));
      last = p % 125;
      run(int'($urandom_range(0, 1500)));
    end
    run(2600);
    chk_lag("random_lag", last * 10);
    chk("random_period", per, 1250);

    // reset mid-period with a shift pending
    apply(7'd60, 1);
    run(2600);
    wait_pos(700);
    apply(7'd30, 1);
    chk("pre_reset_out", {31'd0, clock_out}, 1);
    reset_n = 1'b0;
    #1;
    chk("midreset_out", {31'd0, clock_out}, 0);
    chk("midreset_tick", {31'd0, tick}, 0);
    repeat (3) @(posedge clock_in);
    #1;
    reset_n = 1'b1;
    meas_clr();
    run(2600);
    chk_lag("after_reset_lag", 0);
    chk("after_reset_period", per, 1250);
    chk("after_reset_high", hi_w, 620);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
